buf_updt_ctrl: RTL and testbench

BUF_UPDT_CTRL -- requirements
Module: buf_updt_ctrl

---
 rtl/buf_updt_ctrl.sv | 122 ++++++++++++
 tb/tb_buf_updt_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buf_updt_ctrl.sv
// buf_updt_ctrl: ping-pong tile buffer write controller.
// Streams beats into one bank half while the consumer reads the other.
module buf_updt_ctrl #(
  parameter int BUF_UPDT_ADDR_WIDTH = 8,
  parameter int BUF_UPDT_DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [BUF_UPDT_ADDR_WIDTH:0]       cfg_len,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [BUF_UPDT_DATA_WIDTH-1:0]     s_data,
  input  logic [BUF_UPDT_DATA_WIDTH/8-1:0]   s_strb,
  output logic [BUF_UPDT_DATA_WIDTH/8-1:0]   buf_updt_wr_en,
  output logic                               buf_updt_sel,
  output logic [BUF_UPDT_ADDR_WIDTH-1:0]     buf_updt_addr,
  output logic [BUF_UPDT_DATA_WIDTH-1:0]     buf_updt_data,
  output logic                               exec_tile_valid,
  output logic                               exec_sel,
  input  logic                               exec_tile_done,
  output logic [1:0]                         bank_full
);

  localparam int AW = BUF_UPDT_ADDR_WIDTH;
  localparam int DW = BUF_UPDT_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [AW:0]   LEN_MAX  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic          r_wr_bank;
  logic          r_rd_bank;
  logic          r_pend;
  logic          r_pend_bank;
  logic [AW-1:0] r_wr_addr;
  logic [AW:0]   r_len_q;
  logic [1:0]    r_full;

  logic [SW-1:0] r_wr_en;
  logic          r_sel;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;

  logic          w_accept;
  logic          w_first;
  logic          w_last;
  logic          w_release;
  logic [AW:0]   w_cfg_len;
  logic [AW:0]   w_len;
  logic [1:0]    w_full_nxt;

  assign s_ready = !r_full[r_wr_bank] &&
                   !(r_pend && (r_pend_bank == r_wr_bank));

  assign w_accept  = s_valid && s_ready;
  // 0 (and anything past the bank size) selects a full-depth tile
  assign w_cfg_len = ((cfg_len == '0) || cfg_len[AW]) ? LEN_MAX : cfg_len;
  assign w_first   = (r_wr_addr == '0);
  assign w_len     = w_first ? w_cfg_len : r_len_q;
  assign w_last    = ({1'b0, r_wr_addr} == (w_len - LEN_ONE));
  assign w_release = exec_tile_done && r_full[r_rd_bank];

  // commit of the pending bank and release of the read bank, independently
  always_comb begin
    w_full_nxt = r_full;
    if (r_pend) w_full_nxt[r_pend_bank] = 1'b1;
    if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // bank / address / occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_bank <= 1'b0;
      r_wr_addr   <= '0;
      r_len_q     <= '0;
      r_full      <= '0;
    end else begin
      r_full <= w_full_nxt;
      r_pend <= w_accept && w_last;
      if (w_release) r_rd_bank <= !r_rd_bank;
      if (w_accept && w_last) r_pend_bank <= r_wr_bank;
      if (w_accept) begin
        if (w_first) r_len_q <= w_cfg_len;
        if (w_last) begin
          r_wr_addr <= '0;
          r_wr_bank <= !r_wr_bank;
        end else begin
          r_wr_addr <= r_wr_addr + ADDR_ONE;
        end
      end
    end
  end

  // registered buffer write port, strobes only after an accepted beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_en <= '0;
      r_sel   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (w_accept) begin
      r_wr_en <= s_strb;
      r_sel   <= r_wr_bank;
      r_addr  <= r_wr_addr;
      r_data  <= s_data;
    end else begin
      r_wr_en <= '0;
    end
  end

  assign buf_updt_wr_en  = r_wr_en;
  assign buf_updt_sel    = r_sel;
  assign buf_updt_addr   = r_addr;
  assign buf_updt_data   = r_data;
  assign exec_tile_valid = r_full[r_rd_bank];
  assign exec_sel        = r_rd_bank;
  assign bank_full       = r_full;

endmodule

// File: tb/tb_buf_updt_ctrl.sv
// tb_buf_updt_ctrl: directed scoreboard bench for buf_updt_ctrl.
// Driver queues expected writes; a negedge monitor pops and compares.
module tb_buf_updt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  cfg_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_strb;
  logic [3:0]  buf_updt_wr_en;
  logic        buf_updt_sel;
  logic [7:0]  buf_updt_addr;
  logic [31:0] buf_updt_data;
  logic        exec_tile_valid;
  logic        exec_sel;
  logic        exec_tile_done;
  logic [1:0]  bank_full;

  typedef struct packed {
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;
  bit  acc_prev = 1'b0;

  buf_updt_ctrl #(
    .BUF_UPDT_ADDR_WIDTH(8),
    .BUF_UPDT_DATA_WIDTH(32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_len         (cfg_len),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_strb          (s_strb),
    .buf_updt_wr_en  (buf_updt_wr_en),
    .buf_updt_sel    (buf_updt_sel),
    .buf_updt_addr   (buf_updt_addr),
    .buf_updt_data   (buf_updt_data),
    .exec_tile_valid (exec_tile_valid),
    .exec_sel        (exec_sel),
    .exec_tile_done  (exec_tile_done),
    .bank_full       (bank_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    exec_tile_done = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] st,
                      input logic sel, input logic [7:0] a);
    wr_t e;
    int  n;
    e.sel = sel;
    e.addr = a;
    e.data = d;
    e.strb = st;
    exp_q.push_back(e);
    s_valid = 1'b1;
    s_data = d;
    s_strb = st;
    n = 0;
    while (!s_ready && n < 100) begin
      idle(1);
      n++;
    end
    if (!s_ready) begin
      check("accept_timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
    end else begin
      idle(1);
      s_valid = 1'b0;
    end
  endtask

  task automatic mon_step();
    wr_t a;
    wr_t e;
    if (mon_en) begin
      a = {buf_updt_sel, buf_updt_addr, buf_updt_data, buf_updt_wr_en};
      if (acc_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(a), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("write", 64'(a), 64'(e));
        end
      end else begin
        check("idle_wr_en", 64'(buf_updt_wr_en), 64'd0);
      end
    end
    acc_prev = s_valid && s_ready && rst_n;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cfg_len = 9'd4;
    s_data = '0;
    s_strb = '0;
    do_reset();
    mon_en = 1'b1;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // reset state and ignored release
    check("rst_ready", 64'(s_ready), 64'd1);
    check("rst_tv", 64'(exec_tile_valid), 64'd0);
    check("rst_full", 64'(bank_full), 64'd0);
    check("rst_port", 64'({buf_updt_sel, buf_updt_addr, buf_updt_data}), 64'd0);
    exec_tile_done = 1'b1;
    idle(1);
    exec_tile_done = 1'b0;
    check("done_ignored", 64'({exec_sel, bank_full}), 64'd0);

    // single tile
    for (int k = 0; k < 4; k++) send(32'hA0 + k, 4'hF, 1'b0, 8'(k));
    check("tv_early", 64'(exec_tile_valid), 64'd0);
    idle(1);
    check("tv_rise", 64'(exec_tile_valid), 64'd1);
    check("exec_sel0", 64'(exec_sel), 64'd0);
    check("full_01", 64'(bank_full), 64'd1);
    idle(2);
    check("q_empty1", 64'(exp_q.size()), 64'd0);

    // ping-pong backpressure
    do_reset();
    for (int k = 0; k < 8; k++)
      send(32'hB0 + k, 4'hF, k[2], 8'(k % 4));
    fork
      begin
        for (int k = 0; k < 4; k++) send(32'hC0 + k, 4'hF, 1'b0, 8'(k));
      end
      begin
        idle(6);
        check("pp_full11", 64'(bank_full), 64'd3);
        check("pp_stall", 64'(s_ready), 64'd0);
        check("pp_pending", 64'(exp_q.size()), 64'd1);
        exec_tile_done = 1'b1;
        idle(1);
        exec_tile_done = 1'b0;
        check("pp_full10", 64'(bank_full), 64'd2);
        check("pp_sel1", 64'(exec_sel), 64'd1);
      end
    join
    idle(3);
    check("pp_refill", 64'(bank_full), 64'd3);
    check("q_empty2", 64'(exp_q.size()), 64'd0);

    // commit and release on the same edge
    do_reset();
    for (int k = 0; k < 4; k++) send(32'hD0 + k, 4'hF, 1'b0, 8'(k));
    for (int k = 0; k < 4; k++) send(32'hE0 + k, 4'hF, 1'b1, 8'(k));
    check("cr_before", 64'(bank_full), 64'd1);
    exec_tile_done = 1'b1;
    idle(1);
    exec_tile_done = 1'b0;
    check("cr_full10", 64'(bank_full), 64'd2);
    check("cr_sel1", 64'(exec_sel), 64'd1);
    check("cr_tv", 64'(exec_tile_valid), 64'd1);

    // partial strobe with bubbles
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(32'h5500_0000 + k, 4'h5, 1'b0, 8'(k));
      idle(2);
    end
    check("ps_full", 64'(bank_full), 64'd1);
    check("q_empty3", 64'(exp_q.size()), 64'd0);

    // reset mid-tile discards the partial tile
    do_reset();
    send(32'hF0, 4'hF, 1'b0, 8'd0);
    send(32'hF1, 4'hF, 1'b0, 8'd1);
    idle(1);
    rst_n = 1'b0;
    idle(1);
    check("mr_port", 64'({buf_updt_wr_en, buf_updt_sel, buf_updt_addr,
                          buf_updt_data}), 64'd0);
    check("mr_ready", 64'(s_ready), 64'd1);
    check("mr_full", 64'({exec_tile_valid, bank_full}), 64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) send(32'hF8 + k, 4'hF, 1'b0, 8'(k));
    idle(2);
    check("mr_full01", 64'(bank_full), 64'd1);

    // full-depth tile, cfg change mid-tile applies to the next tile
    do_reset();
    cfg_len = 9'd0;
    for (int k = 0; k < 256; k++) begin
      if (k == 100) cfg_len = 9'd4;
      send(32'h1000 + k, 4'hF, 1'b0, 8'(k));
      if (k == 254) begin
        idle(2);
        check("fd_not_yet", 64'(bank_full), 64'd0);
      end
    end
    idle(2);
    check("fd_full01", 64'(bank_full), 64'd1);
    check("fd_tv", 64'(exec_tile_valid), 64'd1);
    for (int k = 0; k < 4; k++) send(32'h2000 + k, 4'hF, 1'b1, 8'(k));
    idle(2);
    check("fd_full11", 64'(bank_full), 64'd3);
    check("q_empty4", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
